// File: rtl/disk_seq_driver_32bit_pkg.sv
// rtl/disk_seq_driver_32bit_pkg.sv - shared types and constants for the disk point sequencer
package disk_seq_driver_32bit_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_NEXT  = 2'd3
   } seq_state_t;

   typedef struct packed {
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] k;
      logic        last;
   } point_entry_t;

   localparam int          ENTRY_W = 97;
   localparam logic [31:0] FP_ONE  = 32'h0001_0000;

endpackage

// File: rtl/disk_seq_driver_32bit_disk_point_fifo.sv
// rtl/disk_seq_driver_32bit_disk_point_fifo.sv - first-word-fall-through point FIFO
module disk_point_fifo
   import disk_seq_driver_32bit_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_push,
   input  logic [ENTRY_W-1:0] i_data,
   input  logic               i_pop,
   output logic               o_full,
   output logic               o_empty,
   output logic [ENTRY_W-1:0] o_head
);

   localparam int AW = $clog2(DEPTH);

   logic [ENTRY_W-1:0] r_mem [DEPTH];
   logic [AW:0]        r_wr_ptr;
   logic [AW:0]        r_rd_ptr;
   logic               w_wr_en;
   logic               w_rd_en;

   assign w_wr_en = i_push && !o_full;
   assign w_rd_en = i_pop && !o_empty;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

   // Head reads as zero when empty so stale entries never leak onto the outputs.
   assign o_head = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

   // Storage array; no reset needed because the head is masked while empty.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_data;
      end
   end

   // Pointer update; push and pop in the same cycle leave occupancy unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/disk_seq_driver_32bit.sv
// rtl/disk_seq_driver_32bit.sv - sequences k indices through the disk generator; optional watchdog via DISK_SEQ_TIMEOUT_EN
module disk_seq_driver_32bit
   import disk_seq_driver_32bit_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_start,
   input  logic [31:0] cfg_k_start,
   input  logic [31:0] cfg_count,
   input  logic [1:0]  cfg_base_sel0,
   input  logic [1:0]  cfg_base_sel1,
   output logic        busy,
   output logic        seq_done,
   output logic        err,
   output logic        gen_start,
   output logic [31:0] gen_k,
   output logic [1:0]  gen_base_sel0,
   output logic [1:0]  gen_base_sel1,
   input  logic        gen_ready,
   input  logic        gen_done,
   input  logic [31:0] gen_x,
   input  logic [31:0] gen_y,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_x,
   output logic [31:0] out_y,
   output logic [31:0] out_k,
   output logic        out_last
);

   seq_state_t   r_state;
   seq_state_t   w_next_state;
   logic [31:0]  r_k;
   logic [31:0]  r_remaining;
   logic [1:0]   r_sel0;
   logic [1:0]   r_sel1;
   logic         r_seq_done;
   logic         w_issue;
   logic         w_push;
   logic         w_pop;
   logic         w_full;
   logic         w_empty;
   logic         w_timeout_hit;
   logic         w_zero_start;
   point_entry_t w_push_entry;
   point_entry_t w_head;

   assign w_zero_start = (r_state == S_IDLE) && cfg_start && (cfg_count == 32'd0);

`ifdef DISK_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

   logic [TW-1:0] r_wait_cnt;
   logic          r_err;

   // Counts elapsed cycles since the start pulse; loaded as the point is issued.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wait_cnt <= '0;
      end else if (w_issue) begin
         r_wait_cnt <= TW'(1);
      end else if (r_state == S_WAIT) begin
         r_wait_cnt <= r_wait_cnt + TW'(1);
      end
   end

   assign w_timeout_hit = (r_state == S_WAIT) && !gen_done &&
                          (r_wait_cnt == TW'(TIMEOUT_CYCLES - 1));

   // Sticky timeout flag, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (w_timeout_hit) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;
`else
   logic w_unused_timeout;

   assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
   assign w_timeout_hit    = 1'b0;
   assign err              = 1'b0;
`endif

   // Next-state and per-cycle strobes; one generator operation in flight at most.
   always_comb begin
      w_next_state = r_state;
      w_issue      = 1'b0;
      w_push       = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (cfg_start && (cfg_count != 32'd0)) w_next_state = S_ISSUE;
         end
         S_ISSUE: begin
            if (gen_ready && !w_full) begin
               w_issue      = 1'b1;
               w_next_state = S_WAIT;
            end
         end
         S_WAIT: begin
            if (gen_done) begin
               w_push       = 1'b1;
               w_next_state = S_NEXT;
            end else if (w_timeout_hit) begin
               w_next_state = S_IDLE;
            end
         end
         S_NEXT: begin
            w_next_state = (r_remaining == 32'd1) ? S_IDLE : S_ISSUE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // State register plus config latch, index advance and completion pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_k         <= '0;
         r_remaining <= '0;
         r_sel0      <= '0;
         r_sel1      <= '0;
         r_seq_done  <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_seq_done <= w_zero_start || w_timeout_hit ||
                       ((r_state == S_NEXT) && (r_remaining == 32'd1));
         if ((r_state == S_IDLE) && cfg_start) begin
            r_k         <= cfg_k_start;
            r_remaining <= cfg_count;
            r_sel0      <= cfg_base_sel0;
            r_sel1      <= cfg_base_sel1;
         end else if (r_state == S_NEXT) begin
            r_k         <= r_k + 32'd1;
            r_remaining <= r_remaining - 32'd1;
         end
      end
   end

   assign w_push_entry = '{x: gen_x, y: gen_y, k: r_k, last: (r_remaining == 32'd1)};
   assign w_pop        = out_valid && out_ready;

   disk_point_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (w_push_entry),
      .i_pop   (w_pop),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (w_head)
   );

   assign busy          = (r_state != S_IDLE);
   assign seq_done      = r_seq_done;
   assign gen_start     = w_issue;
   assign gen_k         = r_k;
   assign gen_base_sel0 = r_sel0;
   assign gen_base_sel1 = r_sel1;
   assign out_valid     = !w_empty;
   assign out_x         = w_head.x;
   assign out_y         = w_head.y;
   assign out_k         = w_head.k;
   assign out_last      = w_head.last;

endmodule

// File: tb/tb_disk_seq_driver_32bit.sv
// tb/tb_disk_seq_driver_32bit.sv - directed self-checking bench for disk_seq_driver_32bit
module tb_disk_seq_driver_32bit;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_start;
   logic [31:0] cfg_k_start;
   logic [31:0] cfg_count;
   logic [1:0]  cfg_base_sel0;
   logic [1:0]  cfg_base_sel1;
   logic        busy;
   logic        seq_done;
   logic        err;
   logic        gen_start;
   logic [31:0] gen_k;
   logic [1:0]  gen_base_sel0;
   logic [1:0]  gen_base_sel1;
   logic        gen_ready;
   logic        gen_done;
   logic [31:0] gen_x;
   logic [31:0] gen_y;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_x;
   logic [31:0] out_y;
   logic [31:0] out_k;
   logic        out_last;

   int n_cmp = 0;
   int n_mis = 0;

   int          cyc = 0;
   int          sd_cnt = 0;
   int          sd_cyc = 0;
   int          start_cnt = 0;
   int          start_cyc = 0;
   int          cd = 0;
   int          gen_lat = 2;
   logic        gen_en = 1'b1;
   logic [31:0] pk = '0;
   logic        prev_busy = 1'b0;
   logic        busy_at_sd = 1'b0;
   logic        busy_before_sd = 1'b0;
   logic        busy_seen = 1'b0;
   logic        valid_seen = 1'b0;
   logic [31:0] q_gen_k[$];
   logic [96:0] q_out[$];

   always #5 clk = ~clk;

   disk_seq_driver_32bit #(
      .FIFO_DEPTH     (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cfg_start     (cfg_start),
      .cfg_k_start   (cfg_k_start),
      .cfg_count     (cfg_count),
      .cfg_base_sel0 (cfg_base_sel0),
      .cfg_base_sel1 (cfg_base_sel1),
      .busy          (busy),
      .seq_done      (seq_done),
      .err           (err),
      .gen_start     (gen_start),
      .gen_k         (gen_k),
      .gen_base_sel0 (gen_base_sel0),
      .gen_base_sel1 (gen_base_sel1),
      .gen_ready     (gen_ready),
      .gen_done      (gen_done),
      .gen_x         (gen_x),
      .gen_y         (gen_y),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_x         (out_x),
      .out_y         (out_y),
      .out_k         (out_k),
      .out_last      (out_last)
   );

   // Generator stand-in and output monitor, both on the falling edge.
   initial begin
      gen_done = 1'b0;
      gen_x    = '0;
      gen_y    = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (seq_done) begin
            sd_cnt++;
            sd_cyc         = cyc;
            busy_at_sd     = busy;
            busy_before_sd = prev_busy;
         end
         prev_busy  = busy;
         busy_seen  = busy_seen | busy;
         valid_seen = valid_seen | out_valid;
         if (out_valid && out_ready) q_out.push_back({out_x, out_y, out_k, out_last});
         gen_done = 1'b0;
         if (rst) begin
            cd = 0;
         end else begin
            if (cd > 0) begin
               cd--;
               if (cd == 0) begin
                  gen_done = 1'b1;
                  gen_x    = pk << 16;
                  gen_y    = pk * 32'd3;
               end
            end
            if (gen_start) begin
               start_cnt++;
               start_cyc = cyc;
               q_gen_k.push_back(gen_k);
               pk = gen_k;
               if (gen_en) cd = gen_lat;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_seq(input logic [31:0] k0, input logic [31:0] cnt);
      cfg_k_start = k0;
      cfg_count   = cnt;
      cfg_start   = 1'b1;
      tick(1);
      cfg_start   = 1'b0;
   endtask

   task automatic wait_sd(input string tag, input int base, input int budget);
      for (int i = 0; i < budget && sd_cnt == base; i++) tick(1);
      check(tag, (sd_cnt > base), 1'b1);
   endtask

   task automatic check_entry(input string tag, input int idx, input logic [31:0] k, input logic last);
      logic [96:0] e;
      e = q_out[idx];
      check({tag, "_k"}, e[32:1], k);
      check({tag, "_x"}, e[96:65], k << 16);
      check({tag, "_y"}, e[64:33], k * 32'd3);
      check({tag, "_last"}, e[0], last);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_seq_done"}, seq_done, 1'b0);
      check({tag, "_err"}, err, 1'b0);
      check({tag, "_gen_start"}, gen_start, 1'b0);
      check({tag, "_gen_k"}, gen_k, 32'h0);
      check({tag, "_sel0"}, gen_base_sel0, 2'd0);
      check({tag, "_sel1"}, gen_base_sel1, 2'd0);
      check({tag, "_out_valid"}, out_valid, 1'b0);
      check({tag, "_out_x"}, out_x, 32'h0);
      check({tag, "_out_y"}, out_y, 32'h0);
      check({tag, "_out_k"}, out_k, 32'h0);
      check({tag, "_out_last"}, out_last, 1'b0);
   endtask

   initial begin
      int sd0;
      int st0;
      rst           = 1'b1;
      cfg_start     = 1'b0;
      cfg_k_start   = '0;
      cfg_count     = '0;
      cfg_base_sel0 = '0;
      cfg_base_sel1 = '0;
      gen_ready     = 1'b1;
      out_ready     = 1'b1;

      // Reset state
      tick(3);
      check_idle_outputs("rst");
      rst = 1'b0;
      tick(2);
      check_idle_outputs("post_rst");

      // Basic three-point sequence with a free-flowing consumer
      cfg_base_sel0 = 2'd2;
      cfg_base_sel1 = 2'd1;
      q_gen_k.delete();
      q_out.delete();
      sd0 = sd_cnt;
      start_seq(32'd1, 32'd3);
      check("t1_busy_rises", busy, 1'b1);
      wait_sd("t1_done_in_time", sd0, 200);
      check("t1_busy_at_done", busy_at_sd, 1'b0);
      check("t1_busy_before_done", busy_before_sd, 1'b1);
      check("t1_sel0", gen_base_sel0, 2'd2);
      check("t1_sel1", gen_base_sel1, 2'd1);
      check("t1_nstart", q_gen_k.size(), 3);
      if (q_gen_k.size() == 3) begin
         check("t1_gk0", q_gen_k[0], 32'd1);
         check("t1_gk1", q_gen_k[1], 32'd2);
         check("t1_gk2", q_gen_k[2], 32'd3);
      end
      check("t1_nout", q_out.size(), 3);
      if (q_out.size() == 3) begin
         check_entry("t1_e0", 0, 32'd1, 1'b0);
         check_entry("t1_e1", 1, 32'd2, 1'b0);
         check_entry("t1_e2", 2, 32'd3, 1'b1);
      end
      tick(4);
      check("t1_one_pulse", sd_cnt - sd0, 1);
      check("t1_idle_valid", out_valid, 1'b0);

      // Zero-length request
      st0        = start_cnt;
      sd0        = sd_cnt;
      busy_seen  = 1'b0;
      valid_seen = 1'b0;
      start_seq(32'd5, 32'd0);
      tick(6);
      check("t2_no_start", start_cnt - st0, 0);
      check("t2_one_pulse", sd_cnt - sd0, 1);
      check("t2_busy_never", busy_seen, 1'b0);
      check("t2_valid_never", valid_seen, 1'b0);

      // Back-pressure fills the FIFO then drains in order
      out_ready = 1'b0;
      q_out.delete();
      st0 = start_cnt;
      sd0 = sd_cnt;
      start_seq(32'd10, 32'd6);
      tick(60);
      check("t3_stall_starts", start_cnt - st0, 4);
      check("t3_stall_busy", busy, 1'b1);
      check("t3_stall_valid", out_valid, 1'b1);
      check("t3_hold_k", out_k, 32'd10);
      check("t3_hold_x", out_x, 32'h000A_0000);
      check("t3_hold_last", out_last, 1'b0);
      out_ready = 1'b1;
      wait_sd("t3_done_in_time", sd0, 300);
      check("t3_total_starts", start_cnt - st0, 6);
      check("t3_nout", q_out.size(), 6);
      if (q_out.size() == 6) begin
         for (int i = 0; i < 6; i++) begin
            check_entry("t3_e", i, 32'd10 + 32'(i), (i == 5));
         end
      end

      // Index wraps past 0xFFFFFFFF
      q_gen_k.delete();
      q_out.delete();
      sd0 = sd_cnt;
      start_seq(32'hFFFF_FFFE, 32'd3);
      wait_sd("t4_done_in_time", sd0, 200);
      check("t4_nstart", q_gen_k.size(), 3);
      if (q_gen_k.size() == 3) begin
         check("t4_gk0", q_gen_k[0], 32'hFFFF_FFFE);
         check("t4_gk1", q_gen_k[1], 32'hFFFF_FFFF);
         check("t4_gk2", q_gen_k[2], 32'h0000_0000);
      end
      check("t4_nout", q_out.size(), 3);
      if (q_out.size() == 3) begin
         check_entry("t4_e2", 2, 32'h0, 1'b1);
      end

      // Reset while waiting on the second point
      out_ready = 1'b0;
      gen_lat   = 5;
      st0       = start_cnt;
      start_seq(32'd20, 32'd4);
      for (int i = 0; i < 100 && (start_cnt - st0) < 2; i++) tick(1);
      check("t5_second_issued", start_cnt - st0, 2);
      tick(1);
      check("t5_in_wait_busy", busy, 1'b1);
      check("t5_fifo_held", out_valid, 1'b1);
      rst = 1'b1;
      #1;
      check_idle_outputs("t5_in_rst");
      tick(2);
      rst = 1'b0;
      tick(10);
      check_idle_outputs("t5_after_rst");
      out_ready = 1'b1;
      gen_lat   = 2;
      q_out.delete();
      sd0 = sd_cnt;
      start_seq(32'd7, 32'd2);
      wait_sd("t5_restart_done", sd0, 200);
      check("t5_nout", q_out.size(), 2);
      if (q_out.size() == 2) begin
         check_entry("t5_e0", 0, 32'd7, 1'b0);
         check_entry("t5_e1", 1, 32'd8, 1'b1);
      end
      check("t5_err_clear", err, 1'b0);

`ifdef DISK_SEQ_TIMEOUT_EN
      // Watchdog fires when the generator never answers
      gen_en = 1'b0;
      sd0    = sd_cnt;
      start_seq(32'd3, 32'd2);
      wait_sd("t6_done_in_time", sd0, 100);
      check("t6_latency", sd_cyc - start_cyc, 16);
      check("t6_err", err, 1'b1);
      check("t6_busy", busy, 1'b0);
      tick(5);
      check("t6_err_sticky", err, 1'b1);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);
      check("t6_err_cleared", err, 1'b0);
      gen_en = 1'b1;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
